// File: rtl/mem_arb_pkg.sv
// Shared state encoding, error pattern and watchdog sizing for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_WAIT = 2'd1,
      D_WAIT = 2'd2
   } state_t;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

   // Counter wide enough to hold TIMEOUT, never narrower than 8 bits.
   function automatic int wdog_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared instruction/data memory port.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_valid;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_fetch;
   logic              stall_mem;
   logic              err;

   // The arbiter masters the memory port and serves both requesters.
   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      output i_valid, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             stall_fetch, stall_mem, err
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      input  i_valid, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             stall_fetch, stall_mem, err
   );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle counter: cleared while idle, counts wait cycles without ready; timeout_o flags the
// last permitted wait cycle so the abort happens after exactly TIMEOUT cycles. TIMEOUT=0 disables.
module mem_arb_watchdog
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic timeout_o
);
   localparam int CNT_W = wdog_width(TIMEOUT);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (enable_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign timeout_o = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Registered arbiter for the shared memory port; data beats fetch. Access = grant, wait>=1, pulse,
// with no grant during the pulse cycle. Requesters see stall until their pulse; watchdog aborts.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int                ADDR_W   = 30,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_valid_q, i_valid_d;
   logic              d_done_q, d_done_d;
   logic              err_q, err_d;
   logic              wd_timeout;

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (state_q == IDLE),
      .enable_i  ((state_q != IDLE) && !bus.mem_ready),
      .timeout_o (wd_timeout)
   );

   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      err_d       = err_q;
      i_valid_d   = 1'b0;
      d_done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // The pulse cycle never grants: the finishing requester still holds req.
            if (!i_valid_q && !d_done_q) begin
               if (bus.d_req) begin
                  state_d     = D_WAIT;
                  mem_addr_d  = bus.d_addr;
                  mem_we_d    = bus.d_we;
                  mem_wdata_d = bus.d_wdata;
               end else if (bus.i_req) begin
                  state_d    = I_WAIT;
                  mem_addr_d = bus.i_addr;
                  mem_we_d   = 1'b0;
               end
            end
         end
         I_WAIT: begin
            if (bus.mem_ready || wd_timeout) begin
               state_d   = IDLE;
               i_valid_d = 1'b1;
               i_rdata_d = bus.mem_ready ? bus.mem_rdata : ERR_DATA;
               if (!bus.mem_ready) err_d = 1'b1;
            end
         end
         D_WAIT: begin
            if (bus.mem_ready || wd_timeout) begin
               state_d  = IDLE;
               d_done_d = 1'b1;
               if (!mem_we_q) d_rdata_d = bus.mem_ready ? bus.mem_rdata : ERR_DATA;
               if (!bus.mem_ready) err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_valid_q   <= 1'b0;
         d_done_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_valid_q   <= i_valid_d;
         d_done_q    <= d_done_d;
         err_q       <= err_d;
      end
   end

   assign bus.mem_req     = (state_q != IDLE);
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.i_valid     = i_valid_q;
   assign bus.i_rdata     = i_rdata_q;
   assign bus.d_done      = d_done_q;
   assign bus.d_rdata     = d_rdata_q;
   assign bus.err         = err_q;
   assign bus.stall_fetch = bus.i_req && !i_valid_q;
   assign bus.stall_mem   = bus.d_req && !d_done_q;

endmodule
